// File: rtl/exu_bpstat_ctl_if.sv
`default_nettype none
// ============================================================================
// Module      : exu_bpstat_ctl_if
// Description : Bundles the event, control and read-port signals of the
//               branch-prediction statistics block.
//               master : event/control producer and read requester
//               slave  : statistics block (exu_bpstat_ctl)
// Signals     : freeze, flush, clr, snap    control inputs
//               ev_valid/ev_pred_t/ev_pred_nt/ev_flush_upper/ev_cond_misp
//                                           per-pipe event bits [NPIPE]
//               rd_req, rd_idx[3]           read request / counter index
//               rd_ack, rd_data[CNT_W], rd_ovf   read response
// Revision    : 1.0 - initial release
// ============================================================================
interface exu_bpstat_ctl_if #(
    parameter int NPIPE = 2,
    parameter int CNT_W = 32
);
    logic              freeze;
    logic              flush;
    logic [NPIPE-1:0]  ev_valid;
    logic [NPIPE-1:0]  ev_pred_t;
    logic [NPIPE-1:0]  ev_pred_nt;
    logic [NPIPE-1:0]  ev_flush_upper;
    logic [NPIPE-1:0]  ev_cond_misp;
    logic              clr;
    logic              snap;
    logic              rd_req;
    logic [2:0]        rd_idx;
    logic              rd_ack;
    logic [CNT_W-1:0]  rd_data;
    logic              rd_ovf;

    modport master (
        output freeze, flush, ev_valid, ev_pred_t, ev_pred_nt,
               ev_flush_upper, ev_cond_misp, clr, snap, rd_req, rd_idx,
        input  rd_ack, rd_data, rd_ovf
    );

    modport slave (
        input  freeze, flush, ev_valid, ev_pred_t, ev_pred_nt,
               ev_flush_upper, ev_cond_misp, clr, snap, rd_req, rd_idx,
        output rd_ack, rd_data, rd_ovf
    );
endinterface
`default_nettype wire

// File: rtl/exu_bpstat_ctl.sv
`default_nettype none
// ============================================================================
// Module      : exu_bpstat_ctl
// Description : Branch-prediction statistics counters. Six counters collect
//               per-cycle population counts of qualified branch events from
//               NPIPE ALU pipes:
//                 0 PRED  1 MISP  2 COND  3 TKP  4 NTKP  5 CORR
//               Each counter has a sticky overflow flag. A registered
//               one-cycle read port returns the selected counter and flag.
// Ports       : clk  - clock
//               rst  - asynchronous active-high reset
//               bus  - exu_bpstat_ctl_if.slave (events, control, read port)
// Parameters  : NPIPE (1..4), CNT_W (8..64), SAT (1 = saturate, 0 = wrap)
// Config      : RV_BPSTAT_SNAPSHOT_EN - when defined, 'snap' copies all
//               counters/flags into a shadow bank and reads return the
//               shadow bank; otherwise reads return the live counters.
// Revision    : 1.0 - initial release
// ============================================================================
module exu_bpstat_ctl #(
    parameter int NPIPE = 2,
    parameter int CNT_W = 32,
    parameter int SAT   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    exu_bpstat_ctl_if.slave      bus
);

    localparam int C_NCNT = 6;
    localparam bit C_SAT  = (SAT != 0);

    // ------------------------------------------------------------------
    // Event qualification and per-counter hit vectors
    // ------------------------------------------------------------------
    logic [NPIPE-1:0]                 w_q;
    logic [C_NCNT-1:0][NPIPE-1:0]     w_hit;
    logic [C_NCNT-1:0][2:0]           w_inc;
    logic [C_NCNT-1:0][CNT_W:0]       w_sum;
    logic [C_NCNT-1:0][CNT_W-1:0]     w_nxt;
    logic [C_NCNT-1:0]                w_ovf_set;

    always_comb begin
        w_q = bus.ev_valid & (bus.ev_pred_t | bus.ev_pred_nt)
            & {NPIPE{~bus.flush & ~bus.freeze}};
        w_hit[0] = w_q;
        w_hit[1] = w_q & bus.ev_flush_upper;
        w_hit[2] = w_q & bus.ev_cond_misp;
        w_hit[3] = w_q & bus.ev_pred_t;
        w_hit[4] = w_q & bus.ev_pred_nt;
        w_hit[5] = w_q & ~bus.ev_flush_upper;
    end

    // Population count per counter so simultaneous pipe events all land.
    always_comb begin
        w_inc = '0;
        for (int c = 0; c < C_NCNT; c++) begin
            for (int p = 0; p < NPIPE; p++) begin
                w_inc[c] = w_inc[c] + {2'b00, w_hit[c][p]};
            end
        end
    end

    // Counter registers and sticky overflow flags
    logic [C_NCNT-1:0][CNT_W-1:0]     r_cnt;
    logic [C_NCNT-1:0]                r_ovf;

    // One extra bit on the sum exposes the carry; the carry is the
    // overflow condition in both wrap and saturate modes.
    always_comb begin
        for (int c = 0; c < C_NCNT; c++) begin
            w_sum[c]     = {1'b0, r_cnt[c]} + {{(CNT_W-2){1'b0}}, w_inc[c]};
            w_ovf_set[c] = w_sum[c][CNT_W];
            if (C_SAT && w_sum[c][CNT_W]) begin
                w_nxt[c] = '1;
            end else begin
                w_nxt[c] = w_sum[c][CNT_W-1:0];
            end
        end
    end

    // clr wins over events: the clr cycle's events are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_ovf <= '0;
        end else if (bus.clr) begin
            r_cnt <= '0;
            r_ovf <= '0;
        end else begin
            r_cnt <= w_nxt;
            r_ovf <= r_ovf | w_ovf_set;
        end
    end

    // ------------------------------------------------------------------
    // Read source: shadow bank or live counters
    // ------------------------------------------------------------------
    logic [C_NCNT-1:0][CNT_W-1:0]     w_src_cnt;
    logic [C_NCNT-1:0]                w_src_ovf;

`ifdef RV_BPSTAT_SNAPSHOT_EN
    logic [C_NCNT-1:0][CNT_W-1:0]     r_snap_cnt;
    logic [C_NCNT-1:0]                r_snap_ovf;

    // Captures the pre-update values, so snap+clr yields pre-clear data;
    // clr deliberately leaves the shadow bank alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap_cnt <= '0;
            r_snap_ovf <= '0;
        end else if (bus.snap) begin
            r_snap_cnt <= r_cnt;
            r_snap_ovf <= r_ovf;
        end
    end

    assign w_src_cnt = r_snap_cnt;
    assign w_src_ovf = r_snap_ovf;
`else
    logic w_unused_snap;
    assign w_unused_snap = bus.snap;
    assign w_src_cnt     = r_cnt;
    assign w_src_ovf     = r_ovf;
`endif

    // ------------------------------------------------------------------
    // Read port: one-cycle registered response
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  w_rd_sel;
    logic              w_rd_ovf_sel;

    // Indices 6 and 7 select nothing and read back as zero.
    always_comb begin
        w_rd_sel     = '0;
        w_rd_ovf_sel = 1'b0;
        case (bus.rd_idx)
            3'd0: begin w_rd_sel = w_src_cnt[0]; w_rd_ovf_sel = w_src_ovf[0]; end
            3'd1: begin w_rd_sel = w_src_cnt[1]; w_rd_ovf_sel = w_src_ovf[1]; end
            3'd2: begin w_rd_sel = w_src_cnt[2]; w_rd_ovf_sel = w_src_ovf[2]; end
            3'd3: begin w_rd_sel = w_src_cnt[3]; w_rd_ovf_sel = w_src_ovf[3]; end
            3'd4: begin w_rd_sel = w_src_cnt[4]; w_rd_ovf_sel = w_src_ovf[4]; end
            3'd5: begin w_rd_sel = w_src_cnt[5]; w_rd_ovf_sel = w_src_ovf[5]; end
            default: begin w_rd_sel = '0; w_rd_ovf_sel = 1'b0; end
        endcase
    end

    logic              r_rd_ack;
    logic [CNT_W-1:0]  r_rd_data;
    logic              r_rd_ovf;

    // Data and flag are forced to zero whenever no response is presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ack  <= 1'b0;
            r_rd_data <= '0;
            r_rd_ovf  <= 1'b0;
        end else begin
            r_rd_ack  <= bus.rd_req;
            r_rd_data <= bus.rd_req ? w_rd_sel : '0;
            r_rd_ovf  <= bus.rd_req & w_rd_ovf_sel;
        end
    end

    assign bus.rd_ack  = r_rd_ack;
    assign bus.rd_data = r_rd_data;
    assign bus.rd_ovf  = r_rd_ovf;

endmodule
`default_nettype wire

// File: doc/exu_bpstat_ctl.md
EXU_BPSTAT_CTL -- requirements
Module: exu_bpstat_ctl

Interface
REQ-001 The block SHALL have parameter NPIPE, default 2, giving the number of ALU pipes reporting branch events per cycle (legal 1..4).
REQ-002 The block SHALL have parameter CNT_W, default 32, giving the width of every statistics counter (legal 8..64).
REQ-003 The block SHALL have parameter SAT, default 0, where 1 means counters saturate and 0 means counters wrap.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 Port: clk  input  1  the single clock.
REQ-006 Port: rst  input  1  asynchronous active-high reset.
REQ-007 Port: freeze  input  1  pipeline freeze; blocks all event counting.
REQ-008 Port: flush  input  1  global pipeline flush; blocks all event counting.
REQ-009 Port: ev_valid  input  NPIPE  per-pipe valid for the execute-stage instruction.
REQ-010 Port: ev_pred_t / ev_pred_nt  input  NPIPE each  per-pipe predicted-taken / predicted-not-taken.
REQ-011 Port: ev_flush_upper / ev_cond_misp  input  NPIPE each  per-pipe branch flush / conditional mispredict.
REQ-012 Port: clr  input  1  synchronous clear of all counters and overflow flags.
REQ-013 Port: snap  input  1  snapshot request (used only when the Configuration macro is defined).
REQ-014 Port: rd_req  input  1; rd_idx  input  3  read request and counter index.
REQ-015 Port: rd_ack  output  1; rd_data  output  CNT_W; rd_ovf  output  1  read response, value, sticky overflow.

Function
REQ-016 Per pipe p, the qualifier q[p] SHALL be ev_valid[p] & (ev_pred_t[p] | ev_pred_nt[p]) & ~flush & ~freeze.
REQ-017 Counter indices SHALL be: 0 PRED (q); 1 MISP (q & ev_flush_upper); 2 COND (q & ev_cond_misp); 3 TKP (q & ev_pred_t); 4 NTKP (q & ev_pred_nt); 5 CORR (q & ~ev_flush_upper).
REQ-018 Each cycle, each counter SHALL add the population count (0..NPIPE) of pipes satisfying its condition, so simultaneous events from several pipes SHALL NOT be lost.
REQ-019 With SAT=0, a counter SHALL wrap modulo 2^CNT_W; its overflow flag SHALL be set on carry out.
REQ-020 With SAT=1, a counter SHALL clamp at all-ones; its overflow flag SHALL be set when an increment is clamped.
REQ-021 Overflow flags SHALL be sticky until clr or rst.
REQ-022 clr SHALL zero all counters and overflow flags on the next edge; events in the clr cycle SHALL be dropped.
REQ-023 A read SHALL take one cycle: rd_req sampled at edge N gives rd_ack=1 in cycle N+1 with rd_data/rd_ovf equal to the selected value before edge N's update.
REQ-024 Back-to-back rd_req on consecutive cycles SHALL produce back-to-back rd_ack; rd_ack SHALL be 0 in any cycle not following a sampled rd_req.
REQ-025 rd_data and rd_ovf SHALL be 0 whenever rd_ack is 0.
REQ-026 rd_idx 6 or 7 SHALL return rd_data=0, rd_ovf=0 with rd_ack=1.
REQ-027 rd_req coincident with clr SHALL return the pre-clear value.

Reset
REQ-028 rst SHALL asynchronously force all counters, overflow flags, snapshot registers, rd_ack, rd_data and rd_ovf to 0.
REQ-029 A read outstanding when rst asserts SHALL be discarded; no rd_ack SHALL follow reset deassertion.

Configuration
REQ-030 With RV_BPSTAT_SNAPSHOT_EN defined, snap SHALL copy all six counters and overflow flags, pre-update values of that cycle, into a shadow bank, and all reads SHALL return the shadow bank.
REQ-031 With RV_BPSTAT_SNAPSHOT_EN defined, clr SHALL NOT clear the shadow bank; snap and clr in the same cycle SHALL snapshot pre-clear values.
REQ-032 Without RV_BPSTAT_SNAPSHOT_EN, snap SHALL be ignored, no shadow registers SHALL exist, and reads SHALL return live counters.

Verification
REQ-033 NPIPE=2: 10 cycles both pipes valid, pred_t=1, flush_upper=0 -> read PRED=20, TKP=20, CORR=20, MISP=0, NTKP=0.
REQ-034 Pipe0 valid pred_nt with ev_cond_misp=1 and ev_flush_upper=1 for 3 cycles, one cycle with freeze=1 -> MISP=2, COND=2, CORR=0.
REQ-035 CNT_W=8, SAT=0: 257 single PRED events -> PRED=1, rd_ovf=1; SAT=1 -> PRED=255, rd_ovf=1.
REQ-036 PRED=5, clr with a concurrent event and rd_req idx 0 -> rd_data=5; next read -> 0, rd_ovf=0.
REQ-037 With macro: PRED=7, snap, 4 more events -> read idx 0 = 7; without macro -> 11.
REQ-038 rst asserted the cycle after rd_req -> rd_ack stays 0 and all reads afterwards return 0.
